// File: rtl/config_pkg.sv
// Shared types and constants for the configuration-chain loader.
// Optional CRC check is built with CONFIG_CHAIN_LOADER_CRC_EN.
package config_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int unsigned TILE_CONFIG_BITS = 29;
    localparam int unsigned NUM_TILES        = 4;

    localparam int unsigned      CRC_WIDTH = 8;
    localparam logic [CRC_WIDTH-1:0] CRC8_POLY = 8'h07;

endpackage

// File: rtl/config_crc8.sv
// Bit-serial CRC-8, MSB-first, init zero; clear has priority over enable.
module config_crc8
    import config_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 i_clear,
    input  logic                 i_enable,
    input  logic                 i_bit,
    output logic [CRC_WIDTH-1:0] o_crc
);

    logic [CRC_WIDTH-1:0] r_crc;
    logic                 w_feedback;
    logic [CRC_WIDTH-1:0] w_crc_next;

    always_comb begin
        w_feedback = r_crc[CRC_WIDTH-1] ^ i_bit;
        w_crc_next = {r_crc[CRC_WIDTH-2:0], 1'b0} ^ (w_feedback ? CRC8_POLY : '0);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_crc <= '0;
        end else if (i_clear) begin
            r_crc <= '0;
        end else if (i_enable) begin
            r_crc <= w_crc_next;
        end
    end

    assign o_crc = r_crc;

endmodule

// File: rtl/config_chain_loader.sv
// Streams handshaked config words MSB-first into a daisy-chained config shift chain.
// Define CONFIG_CHAIN_LOADER_CRC_EN to append a CRC-8 check word after the chain bits.
module config_chain_loader
    import config_pkg::*;
#(
    parameter int unsigned WORD_WIDTH   = 8,
    parameter int unsigned CHAIN_LENGTH = NUM_TILES * TILE_CONFIG_BITS
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  in_valid,
    input  logic [WORD_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic                  config_enable,
    output logic                  config_data,
    output logic                  busy,
    output logic                  done
`ifdef CONFIG_CHAIN_LOADER_CRC_EN
    ,
    output logic                  crc_error
`endif
);

    localparam int unsigned CNT_WIDTH = $clog2(CHAIN_LENGTH + 1);
    localparam int unsigned IDX_WIDTH = $clog2(WORD_WIDTH);

    state_t r_state;
    state_t w_state_next;

    logic [CNT_WIDTH-1:0]  r_count;
    logic [CNT_WIDTH-1:0]  w_count_next;
    logic [IDX_WIDTH-1:0]  r_bit_idx;
    logic [IDX_WIDTH-1:0]  w_bit_idx_next;
    logic [WORD_WIDTH-1:0] r_word;
    logic [WORD_WIDTH-1:0] w_word_next;

    logic r_in_ready;
    logic r_config_enable;
    logic r_config_data;
    logic w_config_data_next;
    logic r_busy;
    logic r_done;

    logic w_accept;
    logic w_last_chain;
    logic w_last_bit;

    assign w_accept     = in_valid & r_in_ready;
    assign w_last_chain = (r_count == CNT_WIDTH'(CHAIN_LENGTH - 1));
    assign w_last_bit   = (r_bit_idx == '0);

`ifdef CONFIG_CHAIN_LOADER_CRC_EN
    logic                 r_crc_phase;
    logic                 w_crc_phase_next;
    logic                 r_crc_error;
    logic                 w_crc_error_next;
    logic [CRC_WIDTH-1:0] w_crc;
    logic                 w_crc_clear;
    logic                 w_crc_enable;

    // CRC covers exactly the bits presented on config_data while enabled.
    assign w_crc_clear  = abort | (start & ((r_state == IDLE) | (r_state == DONE)));
    assign w_crc_enable = (r_state == SHIFT);

    config_crc8 u_crc (
        .clock    (clock),
        .reset    (reset),
        .i_clear  (w_crc_clear),
        .i_enable (w_crc_enable),
        .i_bit    (r_config_data),
        .o_crc    (w_crc)
    );

    assign crc_error = r_crc_error;
`endif

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; abort overrides everything, start only counts when idle or done
    always_comb begin
        w_state_next = r_state;
        if (abort) begin
            w_state_next = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) w_state_next = LOAD;
                end
                LOAD: begin
                    if (w_accept) begin
`ifdef CONFIG_CHAIN_LOADER_CRC_EN
                        if (r_crc_phase) w_state_next = DONE;
                        else
`endif
                        w_state_next = SHIFT;
                    end
                end
                SHIFT: begin
                    if (w_last_chain) begin
`ifdef CONFIG_CHAIN_LOADER_CRC_EN
                        w_state_next = LOAD;
`else
                        w_state_next = DONE;
`endif
                    end else if (w_last_bit) begin
                        w_state_next = LOAD;
                    end
                end
                DONE: begin
                    if (start) w_state_next = LOAD;
                end
                default: w_state_next = IDLE;
            endcase
        end
    end

    // Datapath next values; leftover bits of the final word are simply never selected
    always_comb begin
        w_count_next       = r_count;
        w_bit_idx_next     = r_bit_idx;
        w_word_next        = r_word;
        w_config_data_next = r_config_data;
`ifdef CONFIG_CHAIN_LOADER_CRC_EN
        w_crc_phase_next   = r_crc_phase;
        w_crc_error_next   = r_crc_error;
`endif
        if (abort) begin
            w_count_next     = '0;
`ifdef CONFIG_CHAIN_LOADER_CRC_EN
            w_crc_phase_next = 1'b0;
            w_crc_error_next = 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        w_count_next     = '0;
`ifdef CONFIG_CHAIN_LOADER_CRC_EN
                        w_crc_phase_next = 1'b0;
                        w_crc_error_next = 1'b0;
`endif
                    end
                end
                LOAD: begin
                    if (w_accept) begin
`ifdef CONFIG_CHAIN_LOADER_CRC_EN
                        if (r_crc_phase) w_crc_error_next = (in_data[CRC_WIDTH-1:0] != w_crc);
                        else
`endif
                        begin
                            w_word_next        = in_data;
                            w_bit_idx_next     = IDX_WIDTH'(WORD_WIDTH - 1);
                            w_config_data_next = in_data[WORD_WIDTH-1];
                        end
                    end
                end
                SHIFT: begin
                    w_count_next = r_count + CNT_WIDTH'(1);
                    if (!w_last_chain && !w_last_bit) begin
                        w_bit_idx_next     = r_bit_idx - IDX_WIDTH'(1);
                        w_config_data_next = r_word[r_bit_idx - IDX_WIDTH'(1)];
                    end
`ifdef CONFIG_CHAIN_LOADER_CRC_EN
                    if (w_last_chain) w_crc_phase_next = 1'b1;
`endif
                end
                default: ;
            endcase
        end
    end

    // Registered outputs are decoded from the next state so they align with r_state
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_count         <= '0;
            r_bit_idx       <= '0;
            r_word          <= '0;
            r_in_ready      <= 1'b0;
            r_config_enable <= 1'b0;
            r_config_data   <= 1'b0;
            r_busy          <= 1'b0;
            r_done          <= 1'b0;
`ifdef CONFIG_CHAIN_LOADER_CRC_EN
            r_crc_phase     <= 1'b0;
            r_crc_error     <= 1'b0;
`endif
        end else begin
            r_count         <= w_count_next;
            r_bit_idx       <= w_bit_idx_next;
            r_word          <= w_word_next;
            r_in_ready      <= (w_state_next == LOAD);
            r_config_enable <= (w_state_next == SHIFT);
            r_config_data   <= w_config_data_next;
            r_busy          <= (w_state_next == LOAD) || (w_state_next == SHIFT);
            r_done          <= (w_state_next == DONE);
`ifdef CONFIG_CHAIN_LOADER_CRC_EN
            r_crc_phase     <= w_crc_phase_next;
            r_crc_error     <= w_crc_error_next;
`endif
        end
    end

    assign in_ready      = r_in_ready;
    assign config_enable = r_config_enable;
    assign config_data   = r_config_data;
    assign busy          = r_busy;
    assign done          = r_done;

endmodule

// File: tb/tb_config_chain_loader.sv
// Directed bench for config_chain_loader: cycle table plus multi-cycle load scenarios.
// CRC scenarios are included when CONFIG_CHAIN_LOADER_CRC_EN is defined.
module tb_config_chain_loader;

    logic       clock;
    logic       reset;
    logic       start;
    logic       abort;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       config_enable;
    logic       config_data;
    logic       busy;
    logic       done;
`ifdef CONFIG_CHAIN_LOADER_CRC_EN
    logic       crc_error;
    localparam int EXP_HS  = 16;
    localparam int EXP_CYC = 132;
`else
    localparam int EXP_HS  = 15;
    localparam int EXP_CYC = 131;
`endif

    config_chain_loader dut (
        .clock         (clock),
        .reset         (reset),
        .start         (start),
        .abort         (abort),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .in_ready      (in_ready),
        .config_enable (config_enable),
        .config_data   (config_data),
        .busy          (busy),
        .done          (done)
`ifdef CONFIG_CHAIN_LOADER_CRC_EN
        ,
        .crc_error     (crc_error)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]   word_tab [16];
    logic [115:0] chain = '0;
    int           en_count = 0;
    int           hs_count = 0;
    int           stall_en_count = 0;
    logic         stalling = 1'b0;

    // Behavioural chain: shifts config_data into the LSB on every enabled cycle
    always @(negedge clock) begin
        if (!reset) begin
            if (config_enable) begin
                chain    <= {chain[114:0], config_data};
                en_count <= en_count + 1;
                if (stalling) stall_en_count <= stall_en_count + 1;
            end
            if (in_valid && in_ready) hs_count <= hs_count + 1;
        end
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [115:0] build_exp();
        logic [115:0] v;
        int k;
        v = '0;
        for (int w = 0; w < 15; w++) begin
            for (int b = 7; b >= 0; b--) begin
                k = 8 * w + (7 - b);
                if (k < 116) v[115 - k] = word_tab[w][b];
            end
        end
        return v;
    endfunction

    function automatic logic [7:0] crc_model(input logic [115:0] s);
        logic [7:0] c;
        logic       fb;
        c = 8'h00;
        for (int i = 115; i >= 0; i--) begin
            fb = c[7] ^ s[i];
            c  = {c[6:0], 1'b0};
            if (fb) c = c ^ 8'h07;
        end
        return c;
    endfunction

    // Start a load and feed words with in_valid high except for the requested stall
    task automatic run_load(input int stall_word, input int stall_len, input int abort_at,
                            input int start_at, output int cycles, output int ens,
                            output int hss, output int st_en);
        int en0, hs0, st0, stall_used, hs_now;
        bit sent_abort, sent_start;
        en0 = en_count; hs0 = hs_count; st0 = stall_en_count;
        stall_used = 0; sent_abort = 0; sent_start = 0; cycles = 0;
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        while (!done && cycles < 400) begin
            hs_now   = hs_count - hs0;
            in_valid = (hs_now < 16);
            in_data  = word_tab[(hs_now < 16) ? hs_now : 15];
            stalling = 1'b0;
            if (hs_now == stall_word && stall_used < stall_len) begin
                in_valid = 1'b0;
                if (in_ready) begin
                    stalling = 1'b1;
                    stall_used++;
                end
            end
            if (!sent_abort && abort_at >= 0 && (en_count - en0) == abort_at) begin
                abort = 1'b1; sent_abort = 1;
            end
            if (!sent_start && start_at >= 0 && (en_count - en0) == start_at) begin
                start = 1'b1; sent_start = 1;
            end
            @(posedge clock); #1;
            cycles++;
            abort = 1'b0; start = 1'b0; stalling = 1'b0;
            if (sent_abort) break;
        end
        in_valid = 1'b0;
        ens   = en_count - en0;
        hss   = hs_count - hs0;
        st_en = stall_en_count - st0;
    endtask

    typedef struct {
        logic       start;
        logic       abort;
        logic       valid;
        logic [7:0] data;
        logic [4:0] exp;      // {in_ready, config_enable, config_data, busy, done}
        logic       chk_data;
    } vec_t;

    vec_t tab [16];

    initial begin
        int cyc, ens, hss, st_en, k, en0;
        logic [115:0] exp_chain;
        logic [4:0]   mask;

        word_tab = '{8'hA5, 8'h3C, 8'h5A, 8'hC3, 8'h0F, 8'hF0, 8'h81, 8'h7E,
                     8'h11, 8'h22, 8'h44, 8'h88, 8'h99, 8'h66, 8'hE7, 8'h00};
        exp_chain   = build_exp();
        word_tab[15] = crc_model(exp_chain);

        tab[0]  = '{1'b1, 1'b0, 1'b0, 8'h00, 5'b10010, 1'b1};
        tab[1]  = '{1'b0, 1'b0, 1'b1, 8'hA5, 5'b01110, 1'b1};
        tab[2]  = '{1'b0, 1'b0, 1'b0, 8'h00, 5'b01010, 1'b1};
        tab[3]  = '{1'b0, 1'b0, 1'b0, 8'h00, 5'b01110, 1'b1};
        tab[4]  = '{1'b0, 1'b0, 1'b0, 8'h00, 5'b01010, 1'b1};
        tab[5]  = '{1'b0, 1'b0, 1'b0, 8'h00, 5'b01010, 1'b1};
        tab[6]  = '{1'b0, 1'b0, 1'b0, 8'h00, 5'b01110, 1'b1};
        tab[7]  = '{1'b0, 1'b0, 1'b0, 8'h00, 5'b01010, 1'b1};
        tab[8]  = '{1'b0, 1'b0, 1'b0, 8'h00, 5'b01110, 1'b1};
        tab[9]  = '{1'b0, 1'b0, 1'b0, 8'h00, 5'b10110, 1'b1};
        tab[10] = '{1'b1, 1'b0, 1'b0, 8'h00, 5'b10110, 1'b1};
        tab[11] = '{1'b0, 1'b0, 1'b1, 8'h3C, 5'b01010, 1'b1};
        tab[12] = '{1'b0, 1'b0, 1'b0, 8'h00, 5'b01010, 1'b1};
        tab[13] = '{1'b0, 1'b0, 1'b0, 8'h00, 5'b01110, 1'b1};
        tab[14] = '{1'b1, 1'b1, 1'b0, 8'h00, 5'b00000, 1'b0};
        tab[15] = '{1'b0, 1'b0, 1'b0, 8'h00, 5'b00000, 1'b0};

        reset = 1'b1; start = 1'b0; abort = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        repeat (3) @(posedge clock);
        #1;
        check("reset_outputs", {in_ready, config_enable, config_data, busy, done}, 5'b00000);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock); #1;
        check("idle_after_reset", {in_ready, config_enable, config_data, busy, done}, 5'b00000);

        // Cycle-by-cycle table: start, first word 0xA5, LOAD wait, ignored start, abort+start
        for (int i = 0; i < 16; i++) begin
            start = tab[i].start; abort = tab[i].abort;
            in_valid = tab[i].valid; in_data = tab[i].data;
            @(posedge clock); #1;
            mask = tab[i].chk_data ? 5'b11111 : 5'b11011;
            check($sformatf("table_row_%0d", i),
                  {in_ready, config_enable, config_data, busy, done} & mask, tab[i].exp & mask);
        end
        start = 1'b0; abort = 1'b0; in_valid = 1'b0;

        // Full load with in_valid always high
        run_load(-1, 0, -1, -1, cyc, ens, hss, st_en);
        check("full_cycles", 128'(cyc), 128'(EXP_CYC));
        check("full_enables", 128'(ens), 128'd116);
        check("full_handshakes", 128'(hss), 128'(EXP_HS));
        check("full_chain", 128'(chain), 128'(exp_chain));
        check("full_done_state", {in_ready, config_enable, busy, done}, 4'b0001);

        // Upstream stall of 5 cycles before word 4
        run_load(3, 5, -1, -1, cyc, ens, hss, st_en);
        check("stall_cycles", 128'(cyc), 128'(EXP_CYC + 5));
        check("stall_enables", 128'(ens), 128'd116);
        check("stall_enable_during_gap", 128'(st_en), 128'd0);
        check("stall_chain", 128'(chain), 128'(exp_chain));

        // Abort after 50 bits, then a fresh full reload
        run_load(-1, 0, 50, -1, cyc, ens, hss, st_en);
        check("abort_state", {in_ready, config_enable, busy, done}, 4'b0000);
        @(posedge clock); #1;
        check("abort_stays_idle", {in_ready, config_enable, busy, done}, 4'b0000);
        run_load(-1, 0, -1, -1, cyc, ens, hss, st_en);
        check("reload_enables", 128'(ens), 128'd116);
        check("reload_chain", 128'(chain), 128'(exp_chain));

        // start while busy at bit 20 must be ignored
        run_load(-1, 0, -1, 20, cyc, ens, hss, st_en);
        check("busy_start_cycles", 128'(cyc), 128'(EXP_CYC));
        check("busy_start_enables", 128'(ens), 128'd116);
        check("busy_start_chain", 128'(chain), 128'(exp_chain));

        // abort together with start while DONE
        start = 1'b1; abort = 1'b1;
        @(posedge clock); #1;
        start = 1'b0; abort = 1'b0;
        check("abort_start_done", {in_ready, config_enable, busy, done}, 4'b0000);

`ifdef CONFIG_CHAIN_LOADER_CRC_EN
        run_load(-1, 0, -1, -1, cyc, ens, hss, st_en);
        check("crc_good", {crc_error, done}, 2'b01);
        word_tab[3] = word_tab[3] ^ 8'h10;
        run_load(-1, 0, -1, -1, cyc, ens, hss, st_en);
        check("crc_bad", {crc_error, done}, 2'b11);
        word_tab[3] = word_tab[3] ^ 8'h10;
        abort = 1'b1;
        @(posedge clock); #1;
        abort = 1'b0;
        check("crc_cleared_by_abort", {crc_error, done}, 2'b00);
`endif

        // Reset asserted after 40 bits: outputs clear without waiting for an edge
        en0 = en_count;
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        k = 0;
        while ((en_count - en0) < 40 && k < 200) begin
            in_valid = 1'b1;
            in_data  = word_tab[(hs_count % 16)];
            @(posedge clock); #1;
            k++;
        end
        check("pre_reset_enables", 128'(en_count - en0), 128'd40);
        #2;
        reset = 1'b1;
        #1;
        check("reset_mid_shift", {in_ready, config_enable, config_data, busy, done}, 5'b00000);
        in_valid = 1'b0;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock); #1;
        check("idle_after_mid_reset", {in_ready, config_enable, config_data, busy, done}, 5'b00000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
